// File: rtl/pcie_fpc_reorder.sv
// Read-completion reorder buffer: issues block read requests, collects out-of-order
// completions into a RAM and streams whole blocks out in request order. Optional FPC_TAG_CHECK_EN.
module pcie_fpc_reorder #(
    parameter int DBITS       = 64,
    parameter int BWORDS_LOG2 = 6,
    parameter int NBLK_LOG2   = 3,
    parameter int MAX_OUT     = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0]             fifo_number,
    input  logic                   rc_valid,
    input  logic [7:0]             rc_tag,
    input  logic [BWORDS_LOG2-1:0] rc_index,
    input  logic [DBITS-1:0]       rc_data,
    output logic                   rr_valid,
    output logic [2:0]             rr_tag_low,
    input  logic                   rr_ready,
    output logic [DBITS-1:0]       o_data,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic                   interrupt,
    output logic [31:0]            status,
    output logic                   error
);
    localparam int PW   = NBLK_LOG2 + 1;
    localparam int RW   = NBLK_LOG2 + BWORDS_LOG2 + 1;
    localparam int AW   = RW - 1;
    localparam int NBLK = 1 << NBLK_LOG2;
    localparam logic [31:0]   BLK_BYTES = 32'((2 ** BWORDS_LOG2) * DBITS / 8);
    localparam logic [PW-1:0] MAX_OUT_P = PW'(MAX_OUT);

    logic [DBITS-1:0] mem [0:(1 << AW)-1];
    logic [DBITS-1:0] rd_data_q;

    logic [PW-1:0]          p_request_q, p_request_d;
    logic [PW-1:0]          p_write_q, p_write_d;
    logic [PW-1:0]          p_drain_q, p_drain_d;
    logic [RW-1:0]          p_read_q, p_read_d;
    logic [NBLK-1:0]        filled_q, filled_d;
    logic [1:0]             holdoff_q, holdoff_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [DBITS-1:0]       sk_data_q [0:1];
    logic [DBITS-1:0]       sk_data_d [0:1];
    logic                   sk_head_q, sk_head_d;
    logic [1:0]             sk_cnt_q, sk_cnt_d;
    logic [BWORDS_LOG2-1:0] o_cnt_q, o_cnt_d;
    logic [31:0]            status_q, status_d;
    logic                   int_q, int_d;

    logic                   acc, wr_en, rd_en, set_fill, w_adv, rr_hs, pop, push, tail, rc_last;
    logic [NBLK_LOG2-1:0]   rc_blk;
    logic [AW-1:0]          wr_addr, rd_addr;
    logic [2:0]             occ;
    logic                   unused_bits;

    assign unused_bits = ^rc_tag;
    assign acc     = rc_valid && (rc_tag[6:4] == fifo_number);
    assign rc_blk  = rc_tag[NBLK_LOG2-1:0];
    assign rc_last = &rc_index;

`ifdef FPC_TAG_CHECK_EN
    logic [NBLK_LOG2-1:0] tag_off;
    logic                 in_rng;
    logic                 err_q, err_d;

    // Block is outstanding iff its distance past p_write is below the request count
    always_comb begin
        tag_off = rc_blk - p_write_q[NBLK_LOG2-1:0];
        in_rng  = {1'b0, tag_off} < (p_request_q - p_write_q);
        wr_en   = acc && in_rng;
        err_d   = err_q | (acc && !in_rng);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign error = err_q;
`else
    assign wr_en = acc;
    assign error = 1'b0;
`endif

    always_comb begin
        wr_addr  = {rc_blk, rc_index};
        rd_addr  = p_read_q[AW-1:0];
        set_fill = wr_en && rc_last;
        w_adv    = filled_q[p_write_q[NBLK_LOG2-1:0]] && (p_write_q != p_request_q);

        filled_d = filled_q;
        if (w_adv)    filled_d[p_write_q[NBLK_LOG2-1:0]] = 1'b0;
        if (set_fill) filled_d[rc_blk] = 1'b1;
        p_write_d = w_adv ? p_write_q + PW'(1) : p_write_q;
        status_d  = w_adv ? status_q + BLK_BYTES : status_q;

        rr_valid    = (holdoff_q == 2'd0) && ((p_request_q - p_drain_q) < MAX_OUT_P);
        rr_tag_low  = 3'(p_request_q[NBLK_LOG2-1:0]);
        rr_hs       = rr_valid && rr_ready;
        p_request_d = rr_hs ? p_request_q + PW'(1) : p_request_q;
        if (rr_hs)                   holdoff_d = 2'd3;
        else if (holdoff_q != 2'd0)  holdoff_d = holdoff_q - 2'd1;
        else                         holdoff_d = holdoff_q;

        o_valid = (sk_cnt_q != 2'd0);
        o_data  = sk_data_q[sk_head_q];
        pop     = o_valid && o_ready;
        push    = rd_valid_q;

        // Occupancy after this cycle counting the word still in the RAM read stage
        occ        = {1'b0, sk_cnt_q} + {2'b0, rd_valid_q} - {2'b0, pop};
        rd_en      = (p_read_q[RW-1:BWORDS_LOG2] != p_write_q) && (occ < 3'd2);
        p_read_d   = rd_en ? p_read_q + RW'(1) : p_read_q;
        rd_valid_d = rd_en;

        tail      = sk_head_q ^ sk_cnt_q[0];
        sk_data_d = sk_data_q;
        if (push) sk_data_d[tail] = rd_data_q;
        sk_head_d = sk_head_q ^ pop;
        sk_cnt_d  = sk_cnt_q + {1'b0, push} - {1'b0, pop};

        o_cnt_d   = pop ? o_cnt_q + BWORDS_LOG2'(1) : o_cnt_q;
        p_drain_d = (pop && (&o_cnt_q)) ? p_drain_q + PW'(1) : p_drain_q;

        int_d = acc && rc_last && rc_tag[7];
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= rc_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_request_q  <= '0;
            p_write_q    <= '0;
            p_drain_q    <= '0;
            p_read_q     <= '0;
            filled_q     <= '0;
            holdoff_q    <= '0;
            rd_valid_q   <= 1'b0;
            sk_data_q[0] <= '0;
            sk_data_q[1] <= '0;
            sk_head_q    <= 1'b0;
            sk_cnt_q     <= '0;
            o_cnt_q      <= '0;
            status_q     <= '0;
            int_q        <= 1'b0;
        end else begin
            p_request_q  <= p_request_d;
            p_write_q    <= p_write_d;
            p_drain_q    <= p_drain_d;
            p_read_q     <= p_read_d;
            filled_q     <= filled_d;
            holdoff_q    <= holdoff_d;
            rd_valid_q   <= rd_valid_d;
            sk_data_q[0] <= sk_data_d[0];
            sk_data_q[1] <= sk_data_d[1];
            sk_head_q    <= sk_head_d;
            sk_cnt_q     <= sk_cnt_d;
            o_cnt_q      <= o_cnt_d;
            status_q     <= status_d;
            int_q        <= int_d;
        end
    end

    assign interrupt = int_q;
    assign status    = status_q;
endmodule

// File: tb/tb_pcie_fpc_reorder.sv
// Directed bench for pcie_fpc_reorder with default parameters: request pacing table,
// in-order reassembly, output stalls, interrupt, foreign-channel filtering and reset.
module tb_pcie_fpc_reorder;
    localparam logic [2:0] FIFO  = 3'd2;
    localparam logic [2:0] WRONG = 3'd5;

    logic        clock, reset;
    logic [2:0]  fifo_number;
    logic        rc_valid;
    logic [7:0]  rc_tag;
    logic [5:0]  rc_index;
    logic [63:0] rc_data;
    logic        rr_valid;
    logic [2:0]  rr_tag_low;
    logic        rr_ready;
    logic [63:0] o_data;
    logic        o_valid, o_ready;
    logic        interrupt;
    logic [31:0] status;
    logic        error;

    int n_pass = 0;
    int n_total = 0;

    pcie_fpc_reorder dut (
        .clock(clock), .reset(reset), .fifo_number(fifo_number),
        .rc_valid(rc_valid), .rc_tag(rc_tag), .rc_index(rc_index), .rc_data(rc_data),
        .rr_valid(rr_valid), .rr_tag_low(rr_tag_low), .rr_ready(rr_ready),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
        .interrupt(interrupt), .status(status), .error(error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       rdy;
        logic       vld;
        logic [2:0] tag;
    } rr_vec_t;

    rr_vec_t vecs [27];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] mkdata(input int gen, input int blk, input int idx);
        return {8'hC0, gen[7:0], blk[7:0], 8'h5A, idx[31:0]};
    endfunction

    function automatic logic [7:0] mktag(input logic t7, input logic [2:0] f, input int blk);
        return {t7, f, 1'b0, blk[2:0]};
    endfunction

    task automatic send_word(input logic [7:0] tag, input int idx, input logic [63:0] d);
        rc_valid = 1'b1;
        rc_tag   = tag;
        rc_index = idx[5:0];
        rc_data  = d;
        @(negedge clock);
        rc_valid = 1'b0;
    endtask

    task automatic send_block(input int blk, input int gen, input int first, input int last);
        for (int i = first; i <= last; i++)
            send_word(mktag(1'b0, FIFO, blk), i, mkdata(gen, blk, i));
    endtask

    // Drains n words expected as consecutive blocks from blk0; leaves o_ready low.
    task automatic collect(input int n, input int blk0, input int gen, input bit toggle);
        int w = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [63:0] prev_data = '0;
        while (w < n && cyc < 4000) begin
            o_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (prev_stall) begin
                chk("stall_valid", {63'b0, o_valid}, 64'd1);
                chk("stall_data", o_data, prev_data);
            end
            if (o_valid && o_ready) begin
                chk("data", o_data, mkdata(gen, (blk0 + w / 64) % 8, w % 64));
                w++;
            end
            prev_stall = o_valid && !o_ready;
            prev_data  = o_data;
            @(negedge clock);
            cyc++;
        end
        o_ready = 1'b0;
        chk("word_count", 64'(w), 64'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic bad;
        vecs[0]  = '{1'b0, 1'b1, 3'd0}; vecs[1]  = '{1'b1, 1'b1, 3'd0}; vecs[2]  = '{1'b1, 1'b0, 3'd1};
        vecs[3]  = '{1'b1, 1'b0, 3'd1}; vecs[4]  = '{1'b1, 1'b0, 3'd1}; vecs[5]  = '{1'b0, 1'b1, 3'd1};
        vecs[6]  = '{1'b1, 1'b1, 3'd1}; vecs[7]  = '{1'b1, 1'b0, 3'd2}; vecs[8]  = '{1'b1, 1'b0, 3'd2};
        vecs[9]  = '{1'b1, 1'b0, 3'd2}; vecs[10] = '{1'b1, 1'b1, 3'd2}; vecs[11] = '{1'b1, 1'b0, 3'd3};
        vecs[12] = '{1'b1, 1'b0, 3'd3}; vecs[13] = '{1'b1, 1'b0, 3'd3}; vecs[14] = '{1'b1, 1'b1, 3'd3};
        vecs[15] = '{1'b1, 1'b0, 3'd4}; vecs[16] = '{1'b1, 1'b0, 3'd4}; vecs[17] = '{1'b1, 1'b0, 3'd4};
        vecs[18] = '{1'b1, 1'b1, 3'd4}; vecs[19] = '{1'b1, 1'b0, 3'd5}; vecs[20] = '{1'b1, 1'b0, 3'd5};
        vecs[21] = '{1'b1, 1'b0, 3'd5}; vecs[22] = '{1'b1, 1'b1, 3'd5}; vecs[23] = '{1'b1, 1'b0, 3'd6};
        vecs[24] = '{1'b1, 1'b0, 3'd6}; vecs[25] = '{1'b1, 1'b0, 3'd6}; vecs[26] = '{1'b1, 1'b0, 3'd6};

        reset = 1'b1; fifo_number = FIFO; rc_valid = 1'b0; rc_tag = '0; rc_index = '0;
        rc_data = '0; rr_ready = 1'b0; o_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_o_valid", {63'b0, o_valid}, 64'd0);
        chk("rst_status", {32'b0, status}, 64'd0);
        chk("rst_interrupt", {63'b0, interrupt}, 64'd0);
        chk("rst_error", {63'b0, error}, 64'd0);

        // Request pacing and the MAX_OUT ceiling
        for (int i = 0; i < 27; i++) begin
            rr_ready = vecs[i].rdy;
            #1;
            chk($sformatf("rr_valid[%0d]", i), {63'b0, rr_valid}, {63'b0, vecs[i].vld});
            chk($sformatf("rr_tag[%0d]", i), {61'b0, rr_tag_low}, {61'b0, vecs[i].tag});
            @(negedge clock);
        end
        rr_ready = 1'b1;
        repeat (20) @(negedge clock);
        #1 chk("rr_stays_low", {63'b0, rr_valid}, 64'd0);

        // Blocks completed 2,1,0; output must start with block 0, 4 cycles after its last word
        send_block(2, 0, 0, 63);
        send_block(1, 0, 0, 63);
        send_block(0, 0, 0, 62);
        send_word(mktag(1'b0, FIFO, 0), 63, mkdata(0, 0, 63));
        @(negedge clock);
        @(negedge clock);
        #1 chk("latency_early", {63'b0, o_valid}, 64'd0);
        @(negedge clock);
        #1 chk("latency_first", {63'b0, o_valid}, 64'd1);
        collect(192, 0, 0, 1'b0);
        chk("status_3blk", {32'b0, status}, 64'd1536);
        repeat (5) @(negedge clock);
        #1 chk("no_extra", {63'b0, o_valid}, 64'd0);

        // Output back-pressure toggling every cycle
        @(negedge clock);
        send_block(3, 1, 0, 63);
        send_block(4, 1, 0, 63);
        collect(128, 3, 1, 1'b1);
        chk("status_5blk", {32'b0, status}, 64'd2560);

        // Interrupt on a tagged last word
        send_block(5, 2, 0, 62);
        #1 chk("irq_idle", {63'b0, interrupt}, 64'd0);
        send_word(mktag(1'b1, FIFO, 5), 63, mkdata(2, 5, 63));
        #1 chk("irq_pulse", {63'b0, interrupt}, 64'd1);
        @(negedge clock);
        #1 chk("irq_single", {63'b0, interrupt}, 64'd0);
        collect(64, 5, 2, 1'b0);
        chk("status_6blk", {32'b0, status}, 64'd3072);

        // Words for another channel must neither write, fill nor interrupt
        send_block(6, 3, 0, 62);
        send_word(mktag(1'b1, WRONG, 6), 63, 64'hDEAD_BEEF_DEAD_BEEF);
        send_word(mktag(1'b0, WRONG, 6), 5, 64'hBAD0_BAD0_BAD0_BAD0);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1 bad = bad | interrupt | o_valid;
            @(negedge clock);
        end
        chk("foreign_ignored", {63'b0, bad}, 64'd0);
        chk("foreign_status", {32'b0, status}, 64'd3072);
        send_word(mktag(1'b0, FIFO, 6), 63, mkdata(3, 6, 63));
        collect(64, 6, 3, 1'b0);
        chk("status_7blk", {32'b0, status}, 64'd3584);

        // Reset in the middle of draining a block
        send_block(7, 4, 0, 63);
        collect(10, 7, 4, 1'b0);
        #1 chk("midblock_busy", {63'b0, o_valid}, 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_o_valid", {63'b0, o_valid}, 64'd0);
        chk("midrst_status", {32'b0, status}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("postrst_rr_valid", {63'b0, rr_valid}, 64'd1);
        chk("postrst_rr_tag", {61'b0, rr_tag_low}, 64'd0);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1 bad = bad | o_valid;
        end
        chk("postrst_no_output", {63'b0, bad}, 64'd0);
        chk("postrst_status", {32'b0, status}, 64'd0);

        // Completion for a block that was never requested
        @(negedge clock);
        rr_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        send_word(mktag(1'b0, FIFO, 7), 63, mkdata(5, 7, 63));
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1 bad = bad | o_valid;
            @(negedge clock);
        end
        chk("unreq_no_output", {63'b0, bad}, 64'd0);
`ifdef FPC_TAG_CHECK_EN
        #1 chk("unreq_error", {63'b0, error}, 64'd1);
`else
        #1 chk("unreq_error", {63'b0, error}, 64'd0);
`endif
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1 chk("error_cleared", {63'b0, error}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
